// File: rtl/bakraid_bank_sched.sv
// Read scheduler between four ROM bank slot managers and one SDRAM read port.
// Optional macro BAKRAID_BANK0_PRIO_EN: bank 0 always wins in IDLE; the pointer advances only on non-bank-0 completions.
module bakraid_bank_sched #(
    parameter int BURST  = 2,
    parameter int TO_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_downloading,
    input  logic [3:0]  i_ba_rd,
    input  logic [21:0] i_ba0_addr,
    input  logic [21:0] i_ba1_addr,
    input  logic [21:0] i_ba2_addr,
    input  logic [21:0] i_ba3_addr,
    output logic [3:0]  o_ba_ack,
    output logic [3:0]  o_ba_dst,
    output logic [3:0]  o_ba_rdy,
    output logic        o_sd_req,
    output logic [1:0]  o_sd_ba,
    output logic [21:0] o_sd_addr,
    input  logic        i_sd_ack,
    input  logic        i_sd_dst,
    input  logic        i_sd_rdy,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_ptr;
    logic [1:0]  r_owner;
    logic [21:0] r_addr;
    logic        r_sd_req;
    logic [7:0]  r_wcnt;
    logic [7:0]  r_tocnt;
    logic        r_err;

    logic [21:0] w_addr [4];
    logic [1:0]  w_pick;
    logic        w_pick_vld;
    logic [3:0]  w_owner_oh;
    logic        w_in_req;
    logic        w_in_data;
    logic        w_grant;
    logic        w_withdraw;
    logic        w_timeout;
    logic        w_done;
    logic        w_cnt_err;
    logic        w_adv;

    assign w_addr[0] = i_ba0_addr;
    assign w_addr[1] = i_ba1_addr;
    assign w_addr[2] = i_ba2_addr;
    assign w_addr[3] = i_ba3_addr;

    // Round-robin pick: scan offsets from high to low so the nearest requester at/after the pointer wins.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_pick     = 2'd0;
        w_pick_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (i_ba_rd[r_ptr + 2'(i)]) begin
                w_pick_vld = 1'b1;
                w_pick     = r_ptr + 2'(i);
            end
        end
`ifdef BAKRAID_BANK0_PRIO_EN
        if (i_ba_rd[0]) begin
            w_pick = 2'd0;
        end
`endif
    end

    assign w_owner_oh = 4'(1) << r_owner;
    assign w_in_req   = (r_state == S_REQ);
    assign w_in_data  = (r_state == S_DATA);
    assign w_grant    = (r_state == S_IDLE) && !i_downloading && w_pick_vld;
    assign w_withdraw = w_in_req && !i_sd_ack && !i_ba_rd[r_owner];
    assign w_timeout  = w_in_data && !i_sd_rdy && (r_tocnt == 8'(TO_CYC - 1));
    assign w_done     = w_in_data && (i_sd_rdy || w_timeout);
    assign w_cnt_err  = w_in_data && i_sd_rdy && (r_wcnt != 8'(BURST - 1));

`ifdef BAKRAID_BANK0_PRIO_EN
    assign w_adv = w_done && (r_owner != 2'd0);
`else
    assign w_adv = w_done;
`endif

    // Controller strobes reach only the owning bank, with no register in the path.
    assign o_ba_ack  = {4{i_sd_ack & w_in_req}} & w_owner_oh;
    assign o_ba_dst  = {4{i_sd_dst & w_in_data}} & w_owner_oh;
    assign o_ba_rdy  = {4{w_done}} & w_owner_oh;
    assign o_sd_req  = r_sd_req;
    assign o_sd_ba   = r_owner;
    assign o_sd_addr = r_addr;
    assign o_busy    = (r_state != S_IDLE);
    assign o_err     = r_err;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_grant) w_state_nxt = S_REQ;
            S_REQ: begin
                if (i_sd_ack) begin
                    w_state_nxt = S_DATA;
                end else if (w_withdraw) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: if (w_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd0;
            r_owner  <= 2'd0;
            r_addr   <= 22'd0;
            r_sd_req <= 1'b0;
            r_wcnt   <= 8'd0;
            r_tocnt  <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant) begin
                r_owner  <= w_pick;
                r_addr   <= w_addr[w_pick];
                r_sd_req <= 1'b1;
            end else if (w_in_req && (i_sd_ack || w_withdraw)) begin
                r_sd_req <= 1'b0;
            end

            if (w_in_req && i_sd_ack) begin
                r_wcnt  <= 8'd0;
                r_tocnt <= 8'd0;
            end else if (w_in_data) begin
                if (i_sd_dst && (r_wcnt != 8'hff)) begin
                    r_wcnt <= r_wcnt + 8'd1;
                end
                r_tocnt <= r_tocnt + 8'd1;
            end

            if (w_timeout || w_cnt_err) begin
                r_err <= 1'b1;
            end

            if (w_adv) begin
                r_ptr <= r_owner + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_bakraid_bank_sched.sv
// Scoreboard bench for bakraid_bank_sched: a request-set/pointer model predicts grants and routed strobes.
module tb_bakraid_bank_sched;

    localparam int BURST  = 2;
    localparam int TO_CYC = 255;

    localparam int K_NORMAL   = 0;
    localparam int K_BADCNT   = 1;
    localparam int K_WITHDRAW = 2;
    localparam int K_ACKDROP  = 3;
    localparam int K_TIMEOUT  = 4;
    localparam int K_RESET    = 5;
    localparam int K_DLMID    = 6;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_downloading;
    logic [3:0]  i_ba_rd;
    logic [21:0] i_ba0_addr, i_ba1_addr, i_ba2_addr, i_ba3_addr;
    logic [3:0]  o_ba_ack, o_ba_dst, o_ba_rdy;
    logic        o_sd_req;
    logic [1:0]  o_sd_ba;
    logic [21:0] o_sd_addr;
    logic        i_sd_ack, i_sd_dst, i_sd_rdy;
    logic        o_busy, o_err;

    bakraid_bank_sched #(.BURST(BURST), .TO_CYC(TO_CYC)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_downloading (i_downloading),
        .i_ba_rd       (i_ba_rd),
        .i_ba0_addr    (i_ba0_addr),
        .i_ba1_addr    (i_ba1_addr),
        .i_ba2_addr    (i_ba2_addr),
        .i_ba3_addr    (i_ba3_addr),
        .o_ba_ack      (o_ba_ack),
        .o_ba_dst      (o_ba_dst),
        .o_ba_rdy      (o_ba_rdy),
        .o_sd_req      (o_sd_req),
        .o_sd_ba       (o_sd_ba),
        .o_sd_addr     (o_sd_addr),
        .i_sd_ack      (i_sd_ack),
        .i_sd_dst      (i_sd_dst),
        .i_sd_rdy      (i_sd_rdy),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [11:0] v;
    } route_t;

    typedef struct {
        logic [1:0]  ba;
        logic [21:0] addr;
    } grant_t;

    route_t exp_route[$];
    grant_t exp_grant[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: outstanding requests, their addresses, rotation pointer, sticky error.
    logic [3:0]  mask;
    logic [21:0] addr_m [4];
    int          ptr_m;
    bit          err_m;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic apply();
        i_ba_rd    = mask;
        i_ba0_addr = addr_m[0];
        i_ba1_addr = addr_m[1];
        i_ba2_addr = addr_m[2];
        i_ba3_addr = addr_m[3];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_sd_ack = 1'b0;
        i_sd_dst = 1'b0;
        i_sd_rdy = 1'b0;
    endtask

    task automatic push_route(input logic [3:0] a, input logic [3:0] d, input logic [3:0] r);
        route_t e;
        e.cyc = cyc;
        e.v   = {a, d, r};
        exp_route.push_back(e);
    endtask

    // Winner = first requester at or after the pointer, wrapping (bank 0 first when the priority build is on).
    function automatic int pick(input logic [3:0] m, input int p);
`ifdef BAKRAID_BANK0_PRIO_EN
        if (m[0]) return 0;
`endif
        for (int i = 0; i < 4; i++) begin
            if (m[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic advance(input int w);
`ifdef BAKRAID_BANK0_PRIO_EN
        if (w == 0) return;
`endif
        ptr_m = (w + 1) % 4;
    endtask

    task automatic do_reset(input bit check_vals);
        i_rst = 1'b1;
        mask  = 4'b0;
        apply();
        #1;
        if (check_vals) begin
            check(o_sd_req == 1'b0, "rst_sd_req", o_sd_req, 0);
            check(o_busy == 1'b0, "rst_busy", o_busy, 0);
            check(o_err == 1'b0, "rst_err", o_err, 0);
            check({o_ba_ack, o_ba_dst, o_ba_rdy} == 12'h0, "rst_route", {o_ba_ack, o_ba_dst, o_ba_rdy}, 0);
            check({o_sd_ba, o_sd_addr} == 24'h0, "rst_sd_addr", {o_sd_ba, o_sd_addr}, 0);
        end
        ptr_m = 0;
        err_m = 0;
        exp_route.delete();
        exp_grant.delete();
        tick();
        i_rst = 1'b0;
    endtask

    // Starts in a cycle where the scheduler is idle; ends in the first idle cycle afterwards.
    task automatic run_txn(input logic [3:0] add_bits, input bit fixed, input logic [21:0] faddr,
                           input int kind, input int ack_dly, input int dl, input bit stray);
        int         w;
        int         nw;
        int         dlc;
        logic [3:0] oh;
        grant_t     g;
        for (int b = 0; b < 4; b++) begin
            if (add_bits[b] && !mask[b]) addr_m[b] = fixed ? faddr : 22'($urandom);
        end
        mask = mask | add_bits;
        apply();
        if (stray) begin
            case ($urandom_range(0, 2))
                0:       i_sd_ack = 1'b1;
                1:       i_sd_dst = 1'b1;
                default: i_sd_rdy = 1'b1;
            endcase
        end
        dlc = dl;
        if (i_downloading && dlc == 0) dlc = 1;
        if (dlc > 0) begin
            i_downloading = 1'b1;
            repeat (dlc) begin
                @(negedge clk);
                check(o_sd_req == 1'b0, "dl_block", o_sd_req, 0);
                tick();
            end
        end
        i_downloading = 1'b0;
        w = pick(mask, ptr_m);
        if (w < 0) return;
        g.ba   = 2'(w);
        g.addr = addr_m[w];
        exp_grant.push_back(g);
        @(negedge clk);
        check(o_busy == 1'b0, "idle_busy", o_busy, 0);
        check(o_sd_req == 1'b0, "idle_req", o_sd_req, 0);
        check(o_err == err_m, "err", o_err, err_m);
        tick();
        oh = 4'(1 << w);
        for (int d = 0; d <= ack_dly; d++) begin
            if (d == ack_dly) begin
                if (kind == K_WITHDRAW) begin
                    mask[w] = 1'b0;
                    apply();
                end else begin
                    i_sd_ack = 1'b1;
                    push_route(oh, 4'h0, 4'h0);
                    if (kind == K_ACKDROP) begin
                        mask[w] = 1'b0;
                        apply();
                    end
                end
            end
            @(negedge clk);
            check(o_sd_req == 1'b1, "req_high", o_sd_req, 1);
            tick();
        end
        if (kind == K_WITHDRAW) return;
        if (kind == K_DLMID) i_downloading = 1'b1;
        if (kind == K_RESET) begin
            i_sd_dst = 1'b1;
            push_route(4'h0, oh, 4'h0);
            tick();
            i_sd_dst = 1'b1;
            i_rst    = 1'b1;
            #1;
            check(o_busy == 1'b0, "arst_busy", o_busy, 0);
            check(o_sd_req == 1'b0, "arst_req", o_sd_req, 0);
            check({o_ba_ack, o_ba_dst, o_ba_rdy} == 12'h0, "arst_route", {o_ba_ack, o_ba_dst, o_ba_rdy}, 0);
            check(o_err == 1'b0, "arst_err", o_err, 0);
            ptr_m = 0;
            err_m = 0;
            exp_route.delete();
            tick();
            i_rst = 1'b0;
            return;
        end
        if (kind == K_TIMEOUT) begin
            repeat (TO_CYC - 1) tick();
            push_route(4'h0, 4'h0, oh);
            err_m = 1;
            tick();
        end else begin
            nw = BURST;
            if (kind == K_BADCNT) nw = ($urandom_range(0, 1) == 0) ? 1 : 3;
            for (int k = 0; k < nw; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                i_sd_dst = 1'b1;
                if (k == nw - 1) i_sd_rdy = 1'b1;
                push_route(4'h0, oh, (k == nw - 1) ? oh : 4'h0);
                tick();
            end
            if (kind == K_BADCNT) err_m = 1;
        end
        advance(w);
        mask[w] = 1'b0;
        apply();
    endtask

    // Monitor: compares grants and routed strobes against the queues whenever the DUT presents them.
    grant_t      mon_g;
    route_t      mon_e;
    grant_t      cur;
    logic        prev_req = 1'b0;
    logic [11:0] got;

    always @(negedge clk) begin
        if (i_rst) begin
            prev_req = 1'b0;
        end else begin
            got = {o_ba_ack, o_ba_dst, o_ba_rdy};
            if (o_sd_req && !prev_req) begin
                check(exp_grant.size() != 0, "grant_unexpected", {o_sd_ba, o_sd_addr}, 0);
                if (exp_grant.size() != 0) begin
                    mon_g = exp_grant.pop_front();
                    check({o_sd_ba, o_sd_addr} == {mon_g.ba, mon_g.addr}, "grant",
                          {o_sd_ba, o_sd_addr}, {mon_g.ba, mon_g.addr});
                    cur = mon_g;
                end
            end
            if (o_busy) begin
                check({o_sd_ba, o_sd_addr} == {cur.ba, cur.addr}, "sd_addr_stable",
                      {o_sd_ba, o_sd_addr}, {cur.ba, cur.addr});
            end
            while (exp_route.size() != 0 && exp_route[0].cyc < cyc) begin
                check(exp_route[0].cyc >= cyc, "route_missed", exp_route[0].cyc, cyc);
                void'(exp_route.pop_front());
            end
            if (exp_route.size() != 0 && exp_route[0].cyc == cyc) begin
                mon_e = exp_route.pop_front();
                check(got == mon_e.v, "route", got, mon_e.v);
            end else begin
                check(got == 12'h0, "route_idle", got, 0);
            end
            prev_req = o_sd_req;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int r;
        logic [3:0] add;
        i_rst         = 1'b1;
        i_downloading = 1'b0;
        i_sd_ack      = 1'b0;
        i_sd_dst      = 1'b0;
        i_sd_rdy      = 1'b0;
        for (int b = 0; b < 4; b++) addr_m[b] = 22'h0;
        mask = 4'b0;
        apply();
        tick();
        tick();
        do_reset(1'b1);

        // Single request on bank 1 with a fixed address and a 3-cycle ack delay.
        run_txn(4'b0010, 1'b1, 22'h12345, K_NORMAL, 3, 0, 1'b0);

        // All banks requesting continuously: rotation order from a fresh pointer.
        do_reset(1'b0);
        repeat (5) run_txn(4'b1111, 1'b0, 22'h0, K_NORMAL, $urandom_range(0, 2), 0, 1'b0);

        // Withdraw bank 2 before ack, then confirm the pointer did not move.
        do_reset(1'b0);
        run_txn(4'b0100, 1'b0, 22'h0, K_WITHDRAW, 2, 0, 1'b0);
        run_txn(4'b1010, 1'b0, 22'h0, K_NORMAL, 1, 0, 1'b0);

        // Timeout on bank 3, download gating on bank 0, async reset mid-burst.
        run_txn(4'b1000, 1'b0, 22'h0, K_TIMEOUT, 1, 0, 1'b0);
        run_txn(4'b0001, 1'b0, 22'h0, K_NORMAL, 0, 4, 1'b0);
        run_txn(4'b0110, 1'b0, 22'h0, K_RESET, 1, 0, 1'b0);

        repeat (40) begin
            add = 4'($urandom_range(0, 15));
            if ((mask | add) == 4'b0) add = 4'(1 << $urandom_range(0, 3));
            r = $urandom_range(0, 99);
            if (r < 45)      kind = K_NORMAL;
            else if (r < 55) kind = K_BADCNT;
            else if (r < 70) kind = K_WITHDRAW;
            else if (r < 80) kind = K_ACKDROP;
            else if (r < 85) kind = K_TIMEOUT;
            else if (r < 90) kind = K_RESET;
            else             kind = K_DLMID;
            run_txn(add, 1'b0, 22'h0, kind, $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
                    $urandom_range(0, 3) == 0);
        end

        i_downloading = 1'b1;
        repeat (4) tick();
        check(exp_grant.size() == 0, "grant_leftover", exp_grant.size(), 0);
        check(exp_route.size() == 0, "route_leftover", exp_route.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bakraid_bank_sched.md
# bakraid_bank_sched

Read scheduler between the four per-bank ROM slot managers (CPU/sound/PCM6, GFX low, GFX high, PCM7/8) and the single SDRAM command port. It picks one pending bank read request, forwards its bank and address to the controller, routes the controller's ack/dst/rdy strobes back to the owning bank only, and tracks the burst with a word counter and a timeout watchdog. Grants are blocked while ROM download is active.

## Interface
- BURST, 2: 16-bit words delivered per read (2 for DOUBLE slots).
- TO_CYC, 255: cycles allowed from SD_ACK to SD_RDY before abort; 8-bit counter.
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- DOWNLOADING  in  1  ROM loader active; no new grants while high.
- BA_RD  in  4  per-bank read request, level, held until BA_RDY.
- BA0_ADDR..BA3_ADDR  in  22 each  per-bank word address.
- BA_ACK  out  4  controller ack routed to the owning bank.
- BA_DST  out  4  data-strobe routed to the owning bank.
- BA_RDY  out  4  burst-complete routed to the owning bank.
- SD_REQ  out  1  read request to the SDRAM controller.
- SD_BA  out  2  bank of the current request.
- SD_ADDR  out  22  address of the current request.
- SD_ACK  in  1  controller accepted the request (1-cycle pulse).
- SD_DST  in  1  one pulse per data word on DATA_READ.
- SD_RDY  in  1  last word of the burst present.
- BUSY  out  1  scheduler not IDLE.
- ERR  out  1  sticky; set on timeout abort, cleared only by RESET.

## Operation
- States: IDLE, REQ, DATA.
- IDLE: if !DOWNLOADING and BA_RD != 0, select owner (arbitration below), latch SD_BA/SD_ADDR from that bank, set SD_REQ=1, go REQ. Otherwise hold.
- REQ: SD_REQ held. On SD_ACK: SD_REQ=0, clear word counter and timeout counter, go DATA. If BA_RD[owner] falls with no SD_ACK in that cycle: withdraw, SD_REQ=0, go IDLE, pointer unchanged. SD_ACK and the fall in the same cycle: ack wins.
- DATA: word counter increments on each SD_DST. Timeout counter increments every cycle. On SD_RDY: go IDLE, advance pointer to owner+1 mod 4. When the timeout counter reaches TO_CYC with no SD_RDY: set ERR, pulse BA_RDY[owner] for one cycle so the slot is not deadlocked, go IDLE, advance pointer. SD_RDY with word count != BURST-1 (counted before the RDY cycle's own DST): ERR set, completion proceeds normally.
- Arbitration: round-robin from the pointer. The first set BA_RD bit at or after the pointer, searching upward with wrap, wins. The pointer resets to 0.
- Routing: BA_ACK = {4{SD_ACK & state==REQ}} & owner_onehot. BA_DST and BA_RDY use the same gating with state==DATA. This path is combinational, with zero added latency. Non-owner bits are always 0.
- DOWNLOADING rising during REQ/DATA: the current transaction completes. It only blocks the next grant.

## Timing
- Reset values: SD_REQ=0, SD_BA=0, SD_ADDR=0, BA_ACK/BA_DST/BA_RDY=0, BUSY=0, ERR=0, state IDLE, pointer 0.
- BA_RD rising at cycle n (IDLE) -> SD_REQ=1, SD_BA/SD_ADDR valid at n+1.
- SD_ACK at cycle m -> BA_ACK[owner] high in cycle m, SD_REQ low at m+1.
- SD_RDY at cycle k -> next grant possible with SD_REQ at k+2 (IDLE at k+1).
- SD_BA/SD_ADDR stable from grant until return to IDLE.
- RESET asserted mid-burst: all outputs immediately take their reset values. Later controller strobes are ignored until the next grant.

## Configuration
- BAKRAID_BANK0_PRIO_EN defined: in IDLE, BA_RD[0] wins regardless of the pointer, so CPU/sound fetches never wait behind GFX. The pointer advances only on non-bank-0 completions.
- BAKRAID_BANK0_PRIO_EN undefined: pure round-robin as above.

## Test plan
- Single request: BA_RD=0010, BA1_ADDR=22'h12345, controller ack after 3 cycles and DST, DST+RDY -> SD_BA=1, SD_ADDR=22'h12345, BA_ACK=0010 once, BA_DST=0010 twice, BA_RDY=0010 once, ERR=0.
- Fairness: BA_RD=1111 held, macro off -> grant order 0,1,2,3,0. With the macro on -> grants are 0 every time BA_RD[0] is set.
- Withdraw: BA_RD[2] set then dropped in REQ before SD_ACK -> SD_REQ falls next cycle, no BA_ACK, state IDLE, pointer unchanged.
- Timeout: grant bank 3, SD_ACK, no SD_RDY for 255 cycles -> BA_RDY=1000 pulse at cycle 255 after ack, ERR=1, BUSY=0.
- Download gating: DOWNLOADING=1 with BA_RD=0001 -> SD_REQ stays 0. DOWNLOADING falls -> SD_REQ=1 next cycle.
- Async reset in DATA: RESET pulse mid-burst -> SD_REQ=0, BA_*=0, BUSY=0 without waiting for a clock edge, ERR=0.
